// File: rtl/vlc_ofdm_pkg.sv
// Shared constants and types for the VLC OFDM receive path.
//   FFT_POINT        samples per OFDM symbol
//   CP_NUM           cyclic-prefix length stripped upstream by time-sync
//   SYM_TOTAL        symbols held in one synced burst
//   CHEST_SYM        leading symbols of a burst used for channel estimation
//   BURST_DATA_SIZE  bytes in one burst (FFT_POINT * SYM_TOTAL)
//   READ_LAT         cycles from a read decision to matching time-sync data
//   FIFO_DEPTH       skid FIFO entries in the symbol reader
//   rd_state_t       symbol reader control states
package vlc_ofdm_pkg;

   localparam int FFT_POINT       = 64;
   localparam int CP_NUM          = 16;
   localparam int SYM_TOTAL       = 12;
   localparam int CHEST_SYM       = 4;
   localparam int BURST_DATA_SIZE = FFT_POINT * SYM_TOTAL;
   localparam int READ_LAT        = 3;
   localparam int FIFO_DEPTH      = 4;
   localparam int RD_PTR_W        = 10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_STREAM   = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_DONE     = 3'd3,
      ST_WAIT_CLR = 3'd4
   } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Small synchronous FIFO that absorbs read data still in flight when the
// downstream stream stalls. Push and pop in the same cycle are allowed;
// flush empties it in one cycle and wins over push/pop.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        drop all entries
//   push         write push_data (caller guarantees not full)
//   push_data    WIDTH-bit entry
//   pop          remove head (caller guarantees not empty)
//   pop_data     current head entry
//   count        number of stored entries
//   empty        count == 0
module rd_skid_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   // Wrap explicitly so non-power-of-2 depths also work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_reg] <= push_data;
   end

   assign pop_data = mem[rd_ptr_reg];
   assign count    = count_reg;
   assign empty    = (count_reg == '0);

endmodule

// File: rtl/timesync_symbol_reader.sv
// Drain stage behind the time-sync block. Once time-sync reports a full
// output buffer, walks read_ptr over the whole burst, lines the returned
// sync_dout up with its read via a flag shift register, and re-emits the
// samples as a backpressured stream with per-symbol framing. tx_done pulses
// once the last sample has been accepted downstream.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   out_buff_full   time-sync buffer holds a complete burst
//   sync_dout       time-sync read data (READ_LAT after the read decision)
//   read_ptr        time-sync buffer read address
//   tx_done         one-cycle pulse: burst fully consumed
//   m_axis_*        sample stream; tlast ends a symbol, tuser[0] starts a
//                   symbol, tuser[1] marks channel-estimation symbols
module timesync_symbol_reader
   import vlc_ofdm_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                out_buff_full,
   input  logic [7:0]          sync_dout,
   output logic [RD_PTR_W-1:0] read_ptr,
   output logic                tx_done,
   output logic [7:0]          m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic [1:0]          m_axis_tuser
);

   localparam int CNT_W  = $clog2(BURST_DATA_SIZE + 1);
   localparam int POS_W  = $clog2(FFT_POINT);
   localparam int SYM_W  = CNT_W - POS_W;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W  = $clog2(FIFO_DEPTH + READ_LAT + 1);
   localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_DATA_SIZE);

   rd_state_t           state_reg, state_next;
   logic [CNT_W-1:0]    issue_cnt_reg;
   logic [CNT_W-1:0]    beat_cnt_reg;
   logic [RD_PTR_W-1:0] read_ptr_reg;
   logic [READ_LAT-1:0] pipe_reg;

   logic                abort;
   logic                beat;
   logic                issue;
   logic                push;
   logic [OCC_W-1:0]    in_flight;
   logic [OCC_W-1:0]    occ_after;
   logic [FCNT_W-1:0]   fifo_count;
   logic                fifo_empty;
   logic [7:0]          fifo_dout;

   // ---------------- control decisions ----------------
   // Losing out_buff_full mid-burst means time-sync dropped the burst;
   // everything in flight is stale and the beat this cycle is discarded.
   assign abort = ((state_reg == ST_STREAM) || (state_reg == ST_DRAIN)) && !out_buff_full;
   assign beat  = m_axis_tvalid && m_axis_tready && !abort;
   assign push  = pipe_reg[READ_LAT-1] && !abort;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < READ_LAT; i++) begin
         in_flight = in_flight + OCC_W'(pipe_reg[i]);
      end
   end

   // Credit: every issued read owns a FIFO slot until it is popped. The slot
   // freed by this cycle's pop is counted so that one FIFO entry plus
   // READ_LAT reads in flight sustain one sample per cycle.
   assign occ_after = OCC_W'(fifo_count) + in_flight - OCC_W'(beat);
   assign issue     = (state_reg == ST_STREAM) && !abort &&
                      (issue_cnt_reg < BURST_CNT) &&
                      (occ_after < OCC_W'(FIFO_DEPTH));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:     if (out_buff_full) state_next = ST_STREAM;
         ST_STREAM: begin
            if (abort)                            state_next = ST_IDLE;
            else if (issue_cnt_reg == BURST_CNT)  state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (abort)                            state_next = ST_IDLE;
            else if (beat_cnt_reg == BURST_CNT)   state_next = ST_DONE;
         end
         ST_DONE:     state_next = ST_WAIT_CLR;
         // Hold until time-sync clears so the same burst is not read twice.
         ST_WAIT_CLR: if (!out_buff_full) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt_reg <= '0;
         beat_cnt_reg  <= '0;
         read_ptr_reg  <= '0;
         pipe_reg      <= '0;
      end else if (abort || (state_reg == ST_DONE)) begin
         issue_cnt_reg <= '0;
         beat_cnt_reg  <= '0;
         pipe_reg      <= '0;
      end else begin
         if (issue) begin
            read_ptr_reg  <= RD_PTR_W'(issue_cnt_reg);
            issue_cnt_reg <= issue_cnt_reg + 1'b1;
         end
         if (beat) beat_cnt_reg <= beat_cnt_reg + 1'b1;
         // Flag marks which cycle's sync_dout belongs to an issued read.
         pipe_reg[0] <= issue;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_reg[i] <= pipe_reg[i-1];
         end
      end
   end

   rd_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (abort),
      .push      (push),
      .push_data (sync_dout),
      .pop       (beat),
      .pop_data  (fifo_dout),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   // ---------------- FSM: outputs ----------------
   // Framing derives from the beat counter; it only advances on a beat, so
   // all stream fields hold while the consumer stalls.
   always_comb begin
      read_ptr        = read_ptr_reg;
      tx_done         = (state_reg == ST_DONE);
      m_axis_tvalid   = !fifo_empty;
      m_axis_tdata    = m_axis_tvalid ? fifo_dout : 8'h00;
      m_axis_tlast    = m_axis_tvalid &&
                        (beat_cnt_reg[POS_W-1:0] == POS_W'(FFT_POINT - 1));
      m_axis_tuser[0] = m_axis_tvalid && (beat_cnt_reg[POS_W-1:0] == '0);
      m_axis_tuser[1] = m_axis_tvalid &&
                        (beat_cnt_reg[CNT_W-1:POS_W] < SYM_W'(CHEST_SYM));
   end

endmodule
